// File: rtl/spdif_frame_ctrl_if.sv
// Subframe input bus from the S/PDIF decoder plus the stereo ready/valid
// stream toward the mixer, bundled for spdif_frame_ctrl.
interface spdif_frame_ctrl_if #(
  parameter int DATA_W = 24
);
  logic                     sf_valid;
  logic [1:0]               sf_pre;
  logic signed [DATA_W-1:0] sf_data;
  logic                     sf_v;
  logic                     sf_u;
  logic                     sf_c;
  logic                     sf_p;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_left;
  logic signed [DATA_W-1:0] out_right;
  logic                     out_invalid;

  modport slave (
    input  sf_valid, sf_pre, sf_data, sf_v, sf_u, sf_c, sf_p, out_ready,
    output out_valid, out_left, out_right, out_invalid
  );

  modport master (
    output sf_valid, sf_pre, sf_data, sf_v, sf_u, sf_c, sf_p, out_ready,
    input  out_valid, out_left, out_right, out_invalid
  );
endinterface

// File: rtl/spdif_frame_ctrl.sv
// S/PDIF frame sequencer: B/M/W ordering, 192-frame block tracking, parity,
// stereo pairing onto a ready/valid stream, channel-status capture, lock/watchdog.
module spdif_frame_ctrl #(
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int DATA_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  spdif_frame_ctrl_if.slave   bus,
  output logic                locked,
  output logic [7:0]          frame_idx,
  output logic [31:0]         cs_word,
  output logic                cs_valid,
  output logic                parity_err,
  output logic                seq_err,
  output logic                overflow
);
  typedef enum logic [1:0] {UNLOCKED, EXP_A, EXP_B} state_t;

  localparam logic [1:0] PRE_B = 2'b01;
  localparam logic [1:0] PRE_M = 2'b10;
  localparam logic [1:0] PRE_W = 2'b11;
  localparam int         WD_W  = $clog2(TIMEOUT + 1);
  localparam int         CNT_W = 4;
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);

  state_t                   state, state_nx;
  logic [7:0]               frame_cnt;
  logic [CNT_W-1:0]         good_cnt, good_nx;
  logic [WD_W-1:0]          wd_cnt;
  logic                     first_frame, cs_ok;
  logic                     accept_a, complete, seq_bad, frame_bad, load, timeout_hit;
  logic                     sf_par_bad;
  logic signed [DATA_W-1:0] a_data_p0;
  logic                     a_v_p0, a_par_bad_p0;
  logic [31:0]              cs_shadow;

  assign sf_par_bad  = ^{bus.sf_data, bus.sf_v, bus.sf_u, bus.sf_c, bus.sf_p};
  assign timeout_hit = !bus.sf_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign frame_bad   = a_par_bad_p0 | sf_par_bad;
  assign locked      = (good_cnt == LOCK_CNT) && (state != UNLOCKED);

  always_comb begin
    state_nx = state;
    accept_a = 1'b0;
    complete = 1'b0;
    seq_bad  = 1'b0;
    if (bus.sf_valid) begin
      case (state)
        UNLOCKED: begin
          if (bus.sf_pre == PRE_B) begin
            accept_a = 1'b1;
            state_nx = EXP_B;
          end
        end
        EXP_A: begin
          if ((bus.sf_pre == PRE_B && frame_cnt == 8'd0) ||
              (bus.sf_pre == PRE_M && frame_cnt != 8'd0)) begin
            accept_a = 1'b1;
            state_nx = EXP_B;
          end else begin
            seq_bad  = 1'b1;
            state_nx = UNLOCKED;
          end
        end
        EXP_B: begin
          if (bus.sf_pre == PRE_W) begin
            complete = 1'b1;
            state_nx = EXP_A;
          end else begin
            seq_bad  = 1'b1;
            state_nx = UNLOCKED;
          end
        end
        default: state_nx = UNLOCKED;
      endcase
    end else if (timeout_hit && state != UNLOCKED) begin
      state_nx = UNLOCKED;
    end
  end

  // The acquisition frame only establishes alignment; lock counting starts after it.
  always_comb begin
    good_nx = good_cnt;
    if (frame_bad)                good_nx = '0;
    else if (first_frame)         good_nx = good_cnt;
    else if (good_cnt != LOCK_CNT) good_nx = good_cnt + 1'b1;
    load = complete && !frame_bad && (good_nx == LOCK_CNT);
  end

  // Stage p0: channel-A fields held until the matching W arrives
  always_ff @(posedge clk) begin
    if (accept_a) begin
      a_data_p0    <= bus.sf_data;
      a_v_p0       <= bus.sf_v;
      a_par_bad_p0 <= sf_par_bad;
      if (state == UNLOCKED)
        cs_shadow[0] <= bus.sf_c;
      else if (frame_cnt < 8'd32)
        cs_shadow[frame_cnt[4:0]] <= bus.sf_c;
    end
  end

  // Stage p1: frame completion, status and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= UNLOCKED;
      frame_cnt       <= '0;
      frame_idx       <= '0;
      good_cnt        <= '0;
      wd_cnt          <= '0;
      first_frame     <= 1'b0;
      cs_ok           <= 1'b0;
      cs_word         <= '0;
      cs_valid        <= 1'b0;
      parity_err      <= 1'b0;
      seq_err         <= 1'b0;
      overflow        <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_left    <= '0;
      bus.out_right   <= '0;
      bus.out_invalid <= 1'b0;
    end else begin
      state      <= state_nx;
      seq_err    <= seq_bad;
      parity_err <= complete && frame_bad;
      cs_valid   <= 1'b0;
      overflow   <= 1'b0;
      if (bus.sf_valid)                      wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT))     wd_cnt <= wd_cnt + 1'b1;

      if (state_nx == UNLOCKED) begin
        good_cnt <= '0;
        cs_ok    <= 1'b0;
      end
      if (accept_a) begin
        if (state == UNLOCKED) begin
          frame_cnt   <= '0;
          first_frame <= 1'b1;
        end
        if (bus.sf_pre == PRE_B) cs_ok <= 1'b1;
      end
      if (complete) begin
        frame_idx   <= frame_cnt;
        frame_cnt   <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
        first_frame <= 1'b0;
        good_cnt    <= good_nx;
        if (frame_bad) begin
          cs_ok <= 1'b0;
        end else if (frame_cnt == 8'd31 && cs_ok) begin
          cs_word  <= cs_shadow;
          cs_valid <= 1'b1;
        end
      end

      if (load) begin
        bus.out_valid   <= 1'b1;
        bus.out_left    <= a_data_p0;
        bus.out_right   <= bus.sf_data;
        bus.out_invalid <= a_v_p0 | bus.sf_v;
        overflow        <= bus.out_valid && !bus.out_ready;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: doc/spdif_frame_ctrl.md
# spdif_frame_ctrl

Frame sequencer sitting between the S/PDIF decoder and the mixer input. It consumes decoded subframes (preamble type, 24-bit audio, V/U/C/P), tracks B/M/W ordering and the 192-frame block position, and checks parity. It pairs channel A/B subframes into stereo samples for a ready/valid consumer, collects channel-status bits, and drives lock/error status used to mute downstream.

## Interface
- LOCK_FRAMES, 4: consecutive good frames required before `locked` asserts (1..15).
- TIMEOUT, 1024: clk cycles without `sf_valid` before forced unlock.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- sf_valid  in  1  one-cycle strobe, subframe fields valid.
- sf_pre  in  2  preamble: 2'b01 B, 2'b10 M, 2'b11 W, 2'b00 illegal.
- sf_data  in  24  audio word, MSB-aligned.
- sf_v, sf_u, sf_c, sf_p  in  1 each  validity, user, channel-status, parity bits.
- out_valid  out  1  stereo sample available.
- out_ready  in  1  consumer accepts when high with `out_valid`.
- out_left, out_right  out  24  sample pair.
- out_invalid  out  1  OR of `sf_v` of both subframes of the pair.
- locked  out  1  sequencer in sync.
- frame_idx  out  8  block position of the last completed frame (0..191).
- cs_word  out  32  channel-status bits 0..31 of channel A; bit i = frame i.
- cs_valid  out  1  one-cycle pulse when `cs_word` updates.
- parity_err, seq_err, overflow  out  1 each  one-cycle error pulses.

## Operation
- States: UNLOCKED, EXP_A, EXP_B.
- UNLOCKED: ignore all except `sf_pre`=B → latch A fields, frame counter=0, go EXP_B.
- EXP_A: B is legal only when the next frame number is 0; M only when it is 1..191. Legal → latch A fields, go EXP_B. Otherwise (W, 00, or B/M at wrong position) → `seq_err`, go UNLOCKED.
- EXP_B: W → frame complete, go EXP_A. Anything else → `seq_err`, go UNLOCKED.
- Frame counter increments on each completed frame and wraps 191→0.
- Parity check: each subframe is good iff `^{sf_data,sf_v,sf_u,sf_c,sf_p}`==0.
- Frame with a parity failure in either subframe:
  - `parity_err` pulses once on completion.
  - Frame is not output; good-frame count clears.
  - Counter still advances; sync is kept.
- Good frames: good-frame count saturates at LOCK_FRAMES. `locked`=1 while count==LOCK_FRAMES and state≠UNLOCKED. Entering UNLOCKED clears `locked` and the count.
- Sample output: only when `locked` (after the count update for this frame) and parity good:
  - load `out_left`/`out_right`/`out_invalid`, set `out_valid`.
  - If `out_valid` was already 1 and `out_ready`=0 that cycle: `overflow` pulses and the new pair overwrites.
  - Handshake: `out_valid` clears on accept unless a new pair loads the same cycle.
- Channel status: `sf_c` of channel A at frame i (0..31) shifts into bit i of a shadow register.
  - On completion of frame 31 with no parity/seq error since frame 0: copy shadow to `cs_word`, pulse `cs_valid`.
  - Any error aborts collection until the next B.
- Watchdog: counts cycles since the last `sf_valid`. On reaching TIMEOUT in any state other than UNLOCKED → go UNLOCKED (no `seq_err`). Counter resets on every `sf_valid`.
- Pending `out_valid` survives unlock; it is not flushed.

## Timing
- Reset: state UNLOCKED; all outputs 0, including `cs_word`, `frame_idx`, `out_*`, and all pulses; counters 0.
- Registered latencies after the `sf_valid` cycle carrying W, all on the next edge:
  - `out_valid`/data.
  - `frame_idx`.
  - `locked` rise.
  - `parity_err`/`overflow`/`cs_valid`.
- `seq_err` is 1 cycle after the offending `sf_valid`; `locked` falls in the same cycle.
- Back-to-back `sf_valid` (every cycle) is supported.
- `rst` mid-frame discards partial A data; the first subframe accepted after reset must be B.

## Test plan
- Sync: B,W then M,W ×4, all data parity-even, `out_ready`=1 → `locked` rises after 4th W. The first output pair is the frame-4 pair (frame_idx=4), with `out_valid` 1 cycle after that W.
- Block wrap: 193 good frames → `frame_idx` 191→0 with B accepted at frame 0. Then M at expected frame 0 → `seq_err`, `locked`=0.
- Parity: flip `sf_p` on channel B of frame 10 (locked) → `parity_err` pulse, no output for frame 10, `locked` falls until 4 more good frames.
- Backpressure: `out_ready`=0 across two good frames → `overflow` pulse on the second. Pair 2 is held; a single accept clears `out_valid`.
- Channel status: C=1 on frames 0,2,31, 0 elsewhere → `cs_word`=32'h8000_0005 with `cs_valid` 1 cycle after W of frame 31. Repeat with a parity error at frame 5 → no `cs_valid`.
- Watchdog: locked, stop `sf_valid` for TIMEOUT cycles → `locked` falls exactly at TIMEOUT, no `seq_err`. Subsequent W ignored; B resyncs.
